// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multicycle ALU execute unit with serial SLL/SRL shifter
// Optional signed-overflow output enabled by defining ALU_EXEC_OVERFLOW_EN.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
`ifdef ALU_EXEC_OVERFLOW_EN
    output logic                   overflow,
`endif
    output logic                   illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int MSB = DATA_WIDTH - 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;
    logic                    r_illegal;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic                    r_dir_right;

    logic                    w_accept;
    logic                    w_is_shift;
    logic                    w_serial;
    logic                    w_illegal;
    logic [DATA_WIDTH-1:0]   w_add;
    logic [DATA_WIDTH-1:0]   w_sub;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    assign w_accept     = start && (r_state != S_SHIFT);
    assign w_is_shift   = (ALUOperation == 4'b1000) || (ALUOperation == 4'b1001);
    assign w_serial     = w_is_shift && (shamt != '0);
    assign w_illegal    = ALUOperation[3] && (ALUOperation[2:1] != 2'b00);
    assign w_add        = A + B;
    assign w_sub        = A - B;
    assign w_shift_next = r_dir_right ? (r_shreg >> 1) : (r_shreg << 1);

    // Shift ops only reach this path with shamt == 0, so the result is B unchanged.
    always_comb begin
        w_alu_result = '0;
        case (ALUOperation)
            4'b0000: w_alu_result = A & B;
            4'b0001: w_alu_result = A | B;
            4'b0010: w_alu_result = ~(A | B);
            4'b0011: w_alu_result = w_add;
            4'b0100: w_alu_result = w_sub;
            4'b0101: w_alu_result = A ^ B;
            4'b0110: w_alu_result = w_add;
            4'b0111: w_alu_result = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
            4'b1000: w_alu_result = B;
            4'b1001: w_alu_result = B;
            default: w_alu_result = '0;
        endcase
    end

`ifdef ALU_EXEC_OVERFLOW_EN
    logic r_overflow;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (ALUOperation == 4'b0011)
            w_ovf = (A[MSB] == B[MSB]) && (w_add[MSB] != A[MSB]);
        else if (ALUOperation == 4'b0100)
            w_ovf = (A[MSB] != B[MSB]) && (w_sub[MSB] != A[MSB]);
    end

    assign overflow = r_overflow;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)
                    w_next_state = w_serial ? S_SHIFT : S_DONE;
                else
                    w_next_state = S_IDLE;
            end
            S_SHIFT: begin
                if (r_cnt == SHAMT_WIDTH'(1))
                    w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
    end

    // The last serial step writes straight into result instead of the shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_dir_right <= 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
            r_overflow  <= 1'b0;
`endif
        end else if (w_accept) begin
            if (w_serial) begin
                r_shreg     <= B;
                r_cnt       <= shamt;
                r_dir_right <= ALUOperation[0];
            end else begin
                r_result    <= w_alu_result;
                r_zero      <= (w_alu_result == '0);
                r_illegal   <= w_illegal;
`ifdef ALU_EXEC_OVERFLOW_EN
                r_overflow  <= w_ovf;
`endif
            end
        end else if (r_state == S_SHIFT) begin
            if (r_cnt == SHAMT_WIDTH'(1)) begin
                r_result    <= w_shift_next;
                r_zero      <= (w_shift_next == '0);
                r_illegal   <= 1'b0;
                r_cnt       <= '0;
`ifdef ALU_EXEC_OVERFLOW_EN
                r_overflow  <= 1'b0;
`endif
            end else begin
                r_shreg     <= w_shift_next;
                r_cnt       <= r_cnt - SHAMT_WIDTH'(1);
            end
        end
    end

    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule
